// File: rtl/therm_decoder_pkg.sv
// therm_pkg: shared constants and helpers for the thermometer decoder.
//   therm_w(n)   -- thermometer width 2**n - 1 for an n-bit binary count
//   is_therm(t)  -- 1 when t is a legal thermometer code (ones packed at bit 0)
//   maj3(a,b,c)  -- 3-input majority vote used for bubble repair
package therm_pkg;

    localparam int DEFAULT_N     = 3;
    localparam int DEFAULT_CNT_W = 8;

    // Widest thermometer word is_therm() can judge (N up to 6).
    localparam int THERM_MAX_W = 63;

    function automatic int therm_w(input int n);
        return (1 << n) - 1;
    endfunction

    // Callers zero-extend narrower words into THERM_MAX_W bits. That does
    // not change the verdict: an all-ones word carries out of its own width
    // either way, and the AND with t is still zero.
    function automatic logic is_therm(input logic [THERM_MAX_W-1:0] t);
        return (t & (t + THERM_MAX_W'(1))) == '0;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/therm_decoder_if.sv
// therm_decoder_if: input and output streams of the thermometer decoder.
//   therm_in/in_valid/in_ready                      -- raw thermometer words in
//   value/bubble_err/uncorr_err/out_valid/out_ready -- decoded results out
// Handshake: a word moves on a rising edge where valid && ready are both 1.
// A source holds valid and its data steady until that edge, and never
// withdraws valid without a transfer. ready may depend combinationally on
// the downstream ready.
// Modports: master = source/sink around the decoder, slave = the decoder.
interface therm_decoder_if import therm_pkg::*; #(
    parameter int N = DEFAULT_N
) ();
    localparam int W = therm_w(N);

    logic [W-1:0] therm_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] value;
    logic         bubble_err;
    logic         uncorr_err;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output therm_in, in_valid, out_ready,
        input  in_ready, value, bubble_err, uncorr_err, out_valid
    );

    modport slave (
        input  therm_in, in_valid, out_ready,
        output in_ready, value, bubble_err, uncorr_err, out_valid
    );

endinterface

// File: rtl/therm_decoder_bubble_fix.sv
// therm_bubble_fix: combinational bubble repair for one thermometer word.
//   raw        in  W -- thermometer word as captured
//   value      out N -- popcount of the majority-corrected word
//   bubble_err out 1 -- raw word is not a legal thermometer code
//   uncorr_err out 1 -- corrected word is still not legal
module therm_bubble_fix import therm_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic [therm_w(N)-1:0] raw,
    output logic [N-1:0]          value,
    output logic                  bubble_err,
    output logic                  uncorr_err
);
    localparam int W = therm_w(N);

    logic [W+1:0]           padded;
    logic [W-1:0]           fixed;
    logic [N-1:0]           count;
    logic [THERM_MAX_W-1:0] raw_ext;
    logic [THERM_MAX_W-1:0] fixed_ext;

    always_comb begin
        // Pad with a 1 below bit 0 and a 0 above the top bit so the end
        // positions vote as if the code continued in its natural direction.
        padded = {1'b0, raw, 1'b1};
        fixed  = '0;
        count  = '0;
        for (int i = 0; i < W; i++) begin
            fixed[i] = maj3(padded[i], padded[i+1], padded[i+2]);
            // Cannot overflow: at most W ones, and W fits in N bits.
            count    = count + N'(fixed[i]);
        end
        raw_ext          = '0;
        raw_ext[W-1:0]   = raw;
        fixed_ext        = '0;
        fixed_ext[W-1:0] = fixed;
    end

    assign value      = count;
    assign bubble_err = !is_therm(raw_ext);
    assign uncorr_err = !is_therm(fixed_ext);

endmodule

// File: rtl/therm_decoder.sv
// therm_decoder: two-stage pipelined thermometer-to-binary decoder.
//   clk       in  1     -- rising-edge clock
//   reset_n   in  1     -- asynchronous active-low reset, empties the pipeline
//   bus       slave     -- therm_in/in_valid/in_ready in, value/flags/out_valid/out_ready out
//   err_clr   in  1     -- synchronous clear of err_count (wins over an increment)
//   err_count out CNT_W -- saturating count of delivered words flagged bubble_err
// S1 captures the raw word; S2 holds the corrected result and drives the
// outputs. Each stage loads when empty or when draining in the same cycle.
module therm_decoder import therm_pkg::*; #(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    therm_decoder_if.slave     bus,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   err_count
);
    localparam int              W       = therm_w(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_data_q,  s1_data_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     value_q,     value_d;
    logic             bubble_q,    bubble_d;
    logic             uncorr_q,    uncorr_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             s2_adv;
    logic             in_fire;
    logic             out_fire;
    logic [N-1:0]     fix_value;
    logic             fix_bubble;
    logic             fix_uncorr;

    therm_bubble_fix #(.N(N)) u_fix (
        .raw        (s1_data_q),
        .value      (fix_value),
        .bubble_err (fix_bubble),
        .uncorr_err (fix_uncorr)
    );

    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready;
        in_fire  = bus.in_valid && (!s1_valid_q || s2_adv);
        out_fire = out_valid_q && bus.out_ready;

        // S1: empties when S2 takes its word, refills from the input.
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.therm_in;
        end

        // S2: result fields only change when a new word arrives, so they
        // stay put while the consumer stalls and while the pipe is idle.
        out_valid_d = out_valid_q;
        value_d     = value_q;
        bubble_d    = bubble_q;
        uncorr_d    = uncorr_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                value_d  = fix_value;
                bubble_d = fix_bubble;
                uncorr_d = fix_uncorr;
            end
        end

        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (out_fire && bubble_q && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            value_q     <= '0;
            bubble_q    <= 1'b0;
            uncorr_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
            bubble_q    <= bubble_d;
            uncorr_q    <= uncorr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready   = !s1_valid_q || s2_adv;
    assign bus.out_valid  = out_valid_q;
    assign bus.value      = value_q;
    assign bus.bubble_err = bubble_q;
    assign bus.uncorr_err = uncorr_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_therm_decoder.sv
// Bench for therm_decoder (N = 3, CNT_W = 2). Stimulus is driven on the
// falling edge; expected results go into exp_q when a word is accepted and
// delivered results go into got_q on each output handshake.
module tb_therm_decoder;
    import therm_pkg::*;

    localparam int N     = 3;
    localparam int W     = 7;
    localparam int CNT_W = 2;
    localparam int RW    = N + 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_count;

    therm_decoder_if #(.N(N)) bus ();

    therm_decoder #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    logic          last_ov;
    logic          last_ir;

    // Reference: explicit majority, popcount, and a "no 0 below a 1" scan.
    function automatic logic [RW-1:0] model(input logic [W-1:0] t);
        logic [W+1:0] x;
        logic [W-1:0] c;
        int           cnt;
        logic         bub;
        logic         unc;
        x   = {1'b0, t, 1'b1};
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            c[i] = (int'(x[i]) + int'(x[i+1]) + int'(x[i+2])) >= 2;
            cnt  = cnt + int'(c[i]);
        end
        bub = 1'b0;
        unc = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            if (!t[i] && t[i+1]) bub = 1'b1;
            if (!c[i] && c[i+1]) unc = 1'b1;
        end
        return {N'(cnt), bub, unc};
    endfunction

    // One clock of stimulus; records handshakes that happen at the next edge.
    task automatic cycle(input logic iv, input logic [W-1:0] t, input logic ordy,
                         input logic clr, output logic acc);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.therm_in  = t;
        bus.out_ready = ordy;
        err_clr       = clr;
        #1;
        last_ov = bus.out_valid;
        last_ir = bus.in_ready;
        acc     = iv && bus.in_ready;
        if (acc) exp_q.push_back(model(t));
        if (bus.out_valid && ordy) got_q.push_back({bus.value, bus.bubble_err, bus.uncorr_err});
    endtask

    task automatic drain(input int budget);
        logic a;
        for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.therm_in  = '0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.value !== '0 || bus.bubble_err !== 1'b0 ||
            bus.uncorr_err !== 1'b0 || err_count !== '0)
            $display("FAIL reset_outputs: ov=%b val=%0d bub=%b unc=%b cnt=%0d, want all 0",
                     bus.out_valid, bus.value, bus.bubble_err, bus.uncorr_err, err_count);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b ov=%b want 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_legal_sweep();
        logic          a;
        logic [W-1:0]  t;
        logic [RW-1:0] g;
        logic [RW-1:0] e;
        for (int k = 0; k <= W; k++) begin
            t = W'((1 << k) - 1);
            cycle(1'b1, t, 1'b1, 1'b0, a);
            if (k == 1) begin
                n_checks++;
                if (last_ov !== 1'b0) $display("FAIL latency_early: ov=%b one edge after accept, want 0", last_ov);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (last_ov !== 1'b1) $display("FAIL latency_2: ov=%b two edges after accept, want 1", last_ov);
                else n_pass++;
            end
        end
        drain(20);
        n_checks++;
        if (got_q.size() != W + 1) $display("FAIL sweep_count: got %0d words want %0d", got_q.size(), W + 1);
        else n_pass++;
        for (int k = 0; k <= W && got_q.size() > 0; k++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== {N'(k), 2'b00} || e !== g)
                $display("FAIL sweep_%0d: got %b want %b (model %b)", k, g, {N'(k), 2'b00}, e);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_bubble_repair();
        logic          a;
        logic [W-1:0]  ins[4];
        logic [RW-1:0] want[4];
        logic [RW-1:0] g;
        logic [RW-1:0] e;
        ins[0] = 7'b0001011; want[0] = {3'd3, 2'b10};
        ins[1] = 7'b0000101; want[1] = {3'd2, 2'b10};
        ins[2] = 7'b0010111; want[2] = {3'd4, 2'b10};
        ins[3] = 7'b0101010; want[3] = {3'd3, 2'b11};
        for (int i = 0; i < 4; i++) cycle(1'b1, ins[i], 1'b1, 1'b0, a);
        drain(20);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q.size() == 0) begin
                $display("FAIL bubble_%0d: no output, want %b", i, want[i]);
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== want[i] || e !== want[i])
                $display("FAIL bubble_%0d: in %b got %b want %b (model %b)", i, ins[i], g, want[i], e);
            else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic          a;
        logic [W-1:0]  words[5];
        int            idx;
        logic [RW-1:0] snap;
        logic [RW-1:0] g;
        logic [RW-1:0] e;
        words[0] = 7'b0000001; words[1] = 7'b0000111; words[2] = 7'b0001011;
        words[3] = 7'b0111111; words[4] = 7'b0000011;
        idx = 0;
        snap = '0;
        for (int cyc = 0; cyc < 40 && (idx < 5 || got_q.size() < 5); cyc++) begin
            cycle(idx < 5, (idx < 5) ? words[idx] : '0, cyc >= 4, 1'b0, a);
            if (a) idx++;
            if (cyc == 2) begin
                snap = {bus.value, bus.bubble_err, bus.uncorr_err};
                n_checks++;
                if (last_ir !== 1'b0 || idx != 2)
                    $display("FAIL bp_in_ready: in_ready=%b accepted=%0d want 0/2", last_ir, idx);
                else n_pass++;
            end
            if (cyc == 3) begin
                n_checks++;
                if (last_ov !== 1'b1 || {bus.value, bus.bubble_err, bus.uncorr_err} !== snap ||
                    snap !== model(words[0]))
                    $display("FAIL bp_stable: ov=%b out=%b held=%b want %b", last_ov,
                             {bus.value, bus.bubble_err, bus.uncorr_err}, snap, model(words[0]));
                else n_pass++;
            end
        end
        n_checks++;
        if (got_q.size() != 5 || exp_q.size() != 5)
            $display("FAIL bp_count: delivered %0d accepted %0d want 5/5", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL bp_order: got %b want %b", g, e);
            else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_err_counter();
        logic         a;
        logic [W-1:0] bub;
        bub = 7'b0001011;
        cycle(1'b0, '0, 1'b1, 1'b1, a);
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (err_count !== 2'd0) $display("FAIL cnt_clear0: got %0d want 0", err_count);
        else n_pass++;
        for (int i = 0; i < 5; i++) cycle(1'b1, bub, 1'b1, 1'b0, a);
        drain(20);
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (err_count !== 2'd3 || got_q.size() != 5)
            $display("FAIL cnt_saturate: got %0d (%0d words) want 3 (5 words)", err_count, got_q.size());
        else n_pass++;
        exp_q.delete(); got_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b1, a);
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (err_count !== 2'd0) $display("FAIL cnt_clear: got %0d want 0", err_count);
        else n_pass++;
        cycle(1'b1, bub, 1'b1, 1'b0, a);
        cycle(1'b1, 7'b0011111, 1'b1, 1'b0, a);
        drain(20);
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (err_count !== 2'd1) $display("FAIL cnt_one: got %0d want 1 (legal word must not count)", err_count);
        else n_pass++;
        exp_q.delete(); got_q.delete();
        cycle(1'b1, bub, 1'b0, 1'b0, a);
        for (int i = 0; i < 10 && !last_ov; i++) cycle(1'b0, '0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b1, 1'b1, a);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL cnt_clr_handshake: delivered %0d want 1", got_q.size());
        else n_pass++;
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (err_count !== 2'd0) $display("FAIL cnt_clr_wins: got %0d want 0", err_count);
        else n_pass++;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic a;
        cycle(1'b1, 7'b0000101, 1'b1, 1'b0, a);
        drain(20);
        cycle(1'b1, 7'b0000001, 1'b0, 1'b0, a);
        cycle(1'b1, 7'b0000011, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, a);
        n_checks++;
        if (last_ov !== 1'b1 || last_ir !== 1'b0 || err_count !== 2'd1)
            $display("FAIL rst_prefill: ov=%b in_ready=%b cnt=%0d want 1/0/1", last_ov, last_ir, err_count);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || err_count !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_async: ov=%b cnt=%0d in_ready=%b want 0/0/1",
                     bus.out_valid, err_count, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
        n_checks++;
        if (last_ov !== 1'b0 || last_ir !== 1'b1 || got_q.size() != 0)
            $display("FAIL rst_flushed: ov=%b in_ready=%b delivered=%0d want 0/1/0",
                     last_ov, last_ir, got_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic          a;
        logic [W-1:0]  t;
        logic [RW-1:0] g;
        logic [RW-1:0] e;
        int            sent;
        sent = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 1) t = W'((1 << $urandom_range(W, 0)) - 1);
            else t = W'($urandom_range((1 << W) - 1, 0));
            cycle($urandom_range(3, 0) != 0, t, $urandom_range(2, 0) != 0, 1'b0, a);
            if (a) sent++;
        end
        drain(40);
        n_checks++;
        if (got_q.size() != sent) $display("FAIL b2b_count: delivered %0d want %0d", got_q.size(), sent);
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL b2b_word: got %b want %b", g, e);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_ov = 1'b0;
        last_ir = 1'b0;
        test_reset();
        test_legal_sweep();
        test_bubble_repair();
        test_backpressure();
        test_err_counter();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
